// File: rtl/mel_pkg.sv
// Shared constants, ROM entry layout and the elaboration-time mel table builder
// for the mel filterbank coefficient generator.
package mel_pkg;
  localparam int N_FILT = 64;
  localparam int N_BIN  = 513;
  localparam int Q_FRAC = 12;
  localparam int Q_ONE  = 1 << Q_FRAC;
  localparam int K_W    = 7;
  localparam int W_W    = 13;
  localparam int ROM_W  = K_W + W_W;
  localparam int FV_W   = 10;

  typedef struct packed {
    logic [K_W-1:0] k;
    logic [W_W-1:0] w;
  } rom_entry_t;

  // Edge frequency in Hz of mel grid point i (0..65), HTK mel scale, 0..8000 Hz.
  function automatic real mel_point(input int i);
    real step;
    step = 2595.0 * $log10(1.0 + 8000.0 / 700.0) / 65.0;
    mel_point = 700.0 * ($pow(10.0, real'(i) * step / 2595.0) - 1.0);
  endfunction

  // {k,w} for FFT bin b: k counts centres at or below the bin, w is the Q1.12
  // position of the bin between grid points k and k+1.
  function automatic rom_entry_t mel_entry(input int b);
    rom_entry_t e;
    real        f;
    real        lo;
    real        hi;
    int         k;
    f = real'(b) * 15.625;
    k = 0;
    for (int i = 1; i <= N_FILT; i++) begin
      if (mel_point(i) <= f) k++;
    end
    lo  = mel_point(k);
    hi  = mel_point(k + 1);
    e.k = K_W'(k);
    e.w = W_W'(int'(real'(Q_ONE) * (f - lo) / (hi - lo)));
    mel_entry = e;
  endfunction
endpackage

// File: rtl/mel_coef_rom.sv
// Per-bin {k,w} table with a registered synchronous read; the table is built at
// elaboration from the mel grid. Disabled or out-of-range reads return {0,0}.
module mel_coef_rom
  import mel_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [FV_W-1:0] i_addr,
  output rom_entry_t      o_entry
);
  rom_entry_t w_table [N_BIN];
  rom_entry_t r_q;

  for (genvar g = 0; g < N_BIN; g++) begin : g_table
    localparam rom_entry_t ENTRY = mel_entry(g);
    assign w_table[g] = ENTRY;
  end

  // NOTE: only the read register is reset; the table itself is constant contents
  // and resetting it would prevent mapping it onto ROM/block memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en && (i_addr < FV_W'(N_BIN))) begin
      r_q <= w_table[i_addr];
    end else begin
      r_q <= '0;
    end
  end

  assign o_entry = r_q;
endmodule

// File: rtl/mel_filter_coef.sv
// Mel filterbank coefficient generator: one FFT bin in, all 64 triangular filter
// weights plus the delayed sample and bin index out, one cycle later.
module mel_filter_coef
  import mel_pkg::*;
#(
  parameter int I_BW = 14,
  parameter int O_BW = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FV_W-1:0]          filter_v,
  input  logic signed [I_BW-1:0]   data_i,
  input  logic                     di_en,
  output logic [O_BW*N_FILT-1:0]   coef,
  output logic signed [O_BW-1:0]   data_o,
  output logic                     do_en,
  output logic [FV_W-1:0]          out_filter_v
);
  rom_entry_t              w_entry;
  logic signed [O_BW-1:0]  w_data;
  logic [W_W-1:0]          w_rem;
  logic [O_BW*N_FILT-1:0]  w_coef;
  logic signed [O_BW-1:0]  r_data;
  logic                    r_en;
  logic [FV_W-1:0]         r_fv;

  mel_coef_rom u_rom (
    .clk     (clk),
    .rst     (rst),
    .i_en    (di_en),
    .i_addr  (filter_v),
    .o_entry (w_entry)
  );

  assign w_data = O_BW'(data_i);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values and the three side-band outputs stay aligned with the ROM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_data <= '0;
      r_fv   <= '0;
    end else begin
      r_en   <= di_en;
      r_data <= di_en ? w_data : '0;
      if (di_en) r_fv <= filter_v;
    end
  end

  assign w_rem = W_W'(Q_ONE) - w_entry.w;

  // NOTE: the bus gets a full default before the loop so no lane can infer a latch.
  always_comb begin
    w_coef = '0;
    for (int i = 0; i < N_FILT; i++) begin
      if (int'(w_entry.k) == i) begin
        w_coef[O_BW*(N_FILT-1-i) +: O_BW] = O_BW'(w_entry.w);
      end else if (int'(w_entry.k) == i + 1) begin
        w_coef[O_BW*(N_FILT-1-i) +: O_BW] = O_BW'(w_rem);
      end
    end
  end

  assign coef         = w_coef;
  assign data_o       = r_data;
  assign do_en        = r_en;
  assign out_filter_v = r_fv;
endmodule

// File: tb/tb_mel_filter_coef.sv
// Directed bench for mel_filter_coef: reset, passthrough, boundaries, gaps and a
// full 0..512 sweep against a mel-grid reference model.
module tb_mel_filter_coef;
  localparam int I_BW = 14;
  localparam int O_BW = 14;
  localparam int NF   = 64;

  logic                    clk;
  logic                    rst;
  logic [9:0]              filter_v;
  logic signed [I_BW-1:0]  data_i;
  logic                    di_en;
  logic [O_BW*NF-1:0]      coef;
  logic signed [O_BW-1:0]  data_o;
  logic                    do_en;
  logic [9:0]              out_filter_v;

  int  n_total;
  int  n_bad;
  real pts [66];
  int  exp_lane [NF];
  int  tri_phase [NF];
  int  tri_prev [NF];
  int  tri_viol;
  int  seen_nz [NF];

  mel_filter_coef #(.I_BW(I_BW), .O_BW(O_BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .filter_v     (filter_v),
    .data_i       (data_i),
    .di_en        (di_en),
    .coef         (coef),
    .data_o       (data_o),
    .do_en        (do_en),
    .out_filter_v (out_filter_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lane(input int i);
    lane = int'(coef[O_BW*(NF-1-i) +: O_BW]);
  endfunction

  // Reference weights straight from the mel grid definition.
  task automatic model_fill(input int fv);
    real f;
    int  k;
    int  w;
    for (int i = 0; i < NF; i++) exp_lane[i] = 0;
    if (fv <= 512) begin
      f = real'(fv) * 15.625;
      k = 0;
      for (int i = 1; i <= 64; i++) if (pts[i] <= f) k++;
      w = int'(4096.0 * (f - pts[k]) / (pts[k+1] - pts[k]));
      if (k <= 63) exp_lane[k] = w;
      if (k >= 1) exp_lane[k-1] = 4096 - w;
    end
  endtask

  task automatic check_coef(input string tag, input int fv);
    int nwrong;
    nwrong = 0;
    model_fill(fv);
    for (int i = 0; i < NF; i++) begin
      if (lane(i) != exp_lane[i]) begin
        if (nwrong == 0) $display("  %s lane %0d got %0d want %0d", tag, i, lane(i), exp_lane[i]);
        nwrong++;
      end
    end
    check({tag, " coef_lanes_wrong"}, nwrong, 0);
  endtask

  task automatic check_zero_coef(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < NF; i++) if (lane(i) != 0) nz++;
    check({tag, " coef_nonzero_lanes"}, nz, 0);
  endtask

  task automatic drive(input bit en, input int fv, input int d);
    di_en    = en;
    filter_v = 10'(fv);
    data_i   = I_BW'(d);
  endtask

  initial begin
    real step;
    int  nz;
    int  i0;
    int  i1;
    int  v;
    n_total  = 0;
    n_bad    = 0;
    tri_viol = 0;
    step = 2595.0 * $log10(1.0 + 8000.0 / 700.0) / 65.0;
    for (int i = 0; i < 66; i++) pts[i] = 700.0 * ($pow(10.0, real'(i) * step / 2595.0) - 1.0);
    for (int i = 0; i < NF; i++) begin
      tri_phase[i] = 0;
      tri_prev[i]  = 0;
      seen_nz[i]   = 0;
    end

    // Reset, with a live input that must be ignored.
    rst = 1'b1;
    drive(1'b1, 100, 77);
    tick();
    tick();
    check("reset do_en", do_en, 0);
    check("reset data_o", data_o, 0);
    check("reset out_filter_v", out_filter_v, 0);
    check_zero_coef("reset");
    rst = 1'b0;

    // Passthrough, including a negative sample.
    drive(1'b1, 5, 1000);
    tick();
    check("pass do_en", do_en, 1);
    check("pass data_o", data_o, 1000);
    check("pass out_filter_v", out_filter_v, 5);
    check_coef("pass bin5", 5);
    drive(1'b1, 37, -1234);
    tick();
    check("neg data_o", data_o, -1234);
    check("neg out_filter_v", out_filter_v, 37);

    // Boundaries.
    drive(1'b1, 0, 1000);
    tick();
    check_zero_coef("bin0");
    drive(1'b1, 512, 1000);
    tick();
    check_zero_coef("bin512");
    check("bin512 out_filter_v", out_filter_v, 512);
    drive(1'b1, 600, 1000);
    tick();
    check_zero_coef("bin600");
    check("bin600 do_en", do_en, 1);
    check("bin600 out_filter_v", out_filter_v, 600);
    check("bin600 data_o", data_o, 1000);

    // Gap: di_en 1,0,1.
    drive(1'b1, 100, 200);
    tick();
    check("gap1 do_en", do_en, 1);
    check_coef("gap1 bin100", 100);
    drive(1'b0, 200, 300);
    tick();
    check("gap2 do_en", do_en, 0);
    check("gap2 data_o", data_o, 0);
    check("gap2 out_filter_v hold", out_filter_v, 100);
    check_zero_coef("gap2");
    drive(1'b1, 300, 400);
    tick();
    check("gap3 do_en", do_en, 1);
    check("gap3 out_filter_v", out_filter_v, 300);
    check("gap3 data_o", data_o, 400);
    check_coef("gap3 bin300", 300);

    // Mid-stream reset drops the in-flight sample.
    drive(1'b1, 250, 555);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst do_en", do_en, 0);
    check("midrst out_filter_v", out_filter_v, 0);
    check_zero_coef("midrst");

    // Full sweep, back to back.
    for (int b = 0; b <= 512; b++) begin
      drive(1'b1, b, 1000);
      tick();
      check($sformatf("sweep b=%0d do_en", b), do_en, 1);
      check($sformatf("sweep b=%0d data_o", b), data_o, 1000);
      check($sformatf("sweep b=%0d out_filter_v", b), out_filter_v, b);
      check_coef($sformatf("sweep b=%0d", b), b);
      nz = 0;
      i0 = -1;
      i1 = -1;
      for (int i = 0; i < NF; i++) begin
        v = lane(i);
        if (v != 0) begin
          nz++;
          seen_nz[i] = 1;
          if (i0 < 0) i0 = i; else i1 = i;
        end
        if (v > 4096) tri_viol++;
        case (tri_phase[i])
          0: if (v > 0) tri_phase[i] = 1;
          1: if (v < tri_prev[i]) tri_phase[i] = (v == 0) ? 3 : 2;
          2: begin
            if (v > tri_prev[i]) tri_viol++;
            if (v == 0) tri_phase[i] = 3;
          end
          default: if (v > 0) tri_viol++;
        endcase
        tri_prev[i] = v;
      end
      if (b >= 1 && b <= 511) begin
        check($sformatf("sweep b=%0d nz_in_1_2", b), (nz >= 1 && nz <= 2) ? 1 : 0, 1);
        if (nz == 2) begin
          check($sformatf("sweep b=%0d adjacent", b), i1 - i0, 1);
          check($sformatf("sweep b=%0d pair_sum", b), lane(i0) + lane(i1), 4096);
        end
      end
    end
    di_en = 1'b0;
    for (int i = 0; i < NF; i++) check($sformatf("cover filter %0d", i), seen_nz[i], 1);
    check("triangle violations", tri_viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
